// File: rtl/seq_isqrt_n_pkg.sv
// rtl/seq_isqrt_n_pkg.sv - shared types and width helpers for the sequential integer square root
//
// Purpose: FSM state encoding and derived-width helpers used by seq_isqrt_n and isqrt_step_n.
// Ports:   none (package).
package seq_isqrt_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Number of CALC iterations: one root bit per iteration.
  function automatic int iter_of(input int width);
    return width / 2;
  endfunction

  // Root width.
  function automatic int rw_of(input int width);
    return width / 2;
  endfunction

  // Trial remainder width: partial remainder (RW+1) plus two operand bits.
  function automatic int pw_of(input int width);
    return width / 2 + 3;
  endfunction

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_w_of(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/seq_isqrt_n_step.sv
// rtl/seq_isqrt_n_step.sv - one restoring square-root digit step (combinational)
//
// Purpose: forms the trial remainder from the partial remainder and the next two operand
//          bits, compares it against (proot<<2)|1 and selects the restored or reduced value.
// Ports:   prem       in  WIDTH/2+1  partial remainder
//          proot      in  WIDTH/2    partial root
//          bits       in  2          next two operand bits (MSB first)
//          prem_next  out WIDTH/2+1  updated partial remainder
//          proot_next out WIDTH/2    updated partial root
//          take       out 1          1 when the trial subtraction was kept
module isqrt_step_n
  import seq_isqrt_n_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH/2:0]   prem,
  input  logic [WIDTH/2-1:0] proot,
  input  logic [1:0]         bits,
  output logic [WIDTH/2:0]   prem_next,
  output logic [WIDTH/2-1:0] proot_next,
  output logic               take
);

  localparam int RW = rw_of(WIDTH);
  localparam int PW = pw_of(WIDTH);

  logic [PW-1:0] trial;
  logic [PW-1:0] test;
  logic [PW:0]   diff;
  logic          unused_bits;

  assign trial = {prem, bits};
  assign test  = {1'b0, proot, 2'b01};

  // Subtract with an extra MSB: that bit is the borrow-out, so trial >= test is
  // exactly "no borrow" and the comparison stays unsigned.
  assign diff = {1'b0, trial} - {1'b0, test};
  assign take = ~diff[PW];

  // The new remainder is bounded by 2*root, so the upper trial/diff bits are zero here.
  assign prem_next  = take ? diff[RW:0] : trial[RW:0];
  // The partial root's MSB is still zero on every iteration, so dropping it is lossless.
  assign proot_next = {proot[RW-2:0], take};

  assign unused_bits = ^{diff[PW-1:RW+1], proot[RW-1]};

endmodule

// File: rtl/seq_isqrt_n.sv
// rtl/seq_isqrt_n.sv - multi-cycle restoring integer square root with start/ready/done handshake
//
// Purpose: computes root = floor(sqrt(din)) (or rounded to nearest when ROUND=1, saturating)
//          and rem = din - floor_root^2, one root bit per clock.
// Ports:   clk    in  1          clock, rising edge
//          rst_n  in  1          asynchronous active-low reset
//          start  in  1          request, accepted when ready=1
//          din    in  WIDTH      radicand, sampled on the accepting edge
//          ready  out 1          high in IDLE and DONE
//          busy   out 1          high in CALC and FIX
//          done   out 1          one-cycle completion pulse
//          root   out WIDTH/2    result root, held until the next completion
//          rem    out WIDTH/2+1  unrounded remainder, held until the next completion
module seq_isqrt_n
  import seq_isqrt_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);

  localparam int ITER = iter_of(WIDTH);
  localparam int RW   = rw_of(WIDTH);
  localparam int CW   = cnt_w_of(WIDTH);

  state_t         state, state_next;
  logic [WIDTH-1:0] op;
  logic [RW-1:0]  proot, proot_next;
  logic [RW:0]    prem, prem_next;
  logic [CW-1:0]  cnt;
  logic           unused_take;
  logic [RW:0]    inc;
  logic [RW-1:0]  round_root;

  isqrt_step_n #(.WIDTH(WIDTH)) u_step (
    .prem       (prem),
    .proot      (proot),
    .bits       (op[WIDTH-1:WIDTH-2]),
    .prem_next  (prem_next),
    .proot_next (proot_next),
    .take       (unused_take)
  );

  // Round up when rem > root, i.e. din >= root^2 + root + 1 > (root + 0.5)^2.
  assign inc        = {1'b0, proot} + {{RW{1'b0}}, 1'b1};
  assign round_root = (prem > {1'b0, proot}) ? (inc[RW] ? {RW{1'b1}} : inc[RW-1:0]) : proot;

  assign ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy  = (state == ST_CALC) || (state == ST_FIX);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: state_next = start ? ST_CALC : ST_IDLE;
      ST_CALC: begin
        if (cnt == '0) begin
          state_next = (ROUND != 0) ? ST_FIX : ST_DONE;
        end
      end
      ST_FIX:  state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op    <= '0;
      proot <= '0;
      prem  <= '0;
      cnt   <= '0;
      root  <= '0;
      rem   <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op    <= din;
            proot <= '0;
            prem  <= '0;
            cnt   <= CW'(ITER - 1);
          end
        end
        ST_CALC: begin
          prem  <= prem_next;
          proot <= proot_next;
          op    <= {op[WIDTH-3:0], 2'b00};
          cnt   <= cnt - CW'(1);
          if (cnt == '0 && ROUND == 0) begin
            root <= proot_next;
            rem  <= prem_next;
          end
        end
        ST_FIX: begin
          root <= round_root;
          rem  <= prem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_isqrt_n.sv
// tb/tb_seq_isqrt_n.sv - directed self-checking bench for seq_isqrt_n (floor and round variants)
module tb_seq_isqrt_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] din0 = '0, din1 = '0;
  logic        ready0, busy0, done0, ready1, busy1, done1;
  logic [7:0]  root0, root1;
  logic [8:0]  rem0, rem1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seq_isqrt_n #(.WIDTH(16), .ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .din(din0),
    .ready(ready0), .busy(busy0), .done(done0), .root(root0), .rem(rem0)
  );

  seq_isqrt_n #(.WIDTH(16), .ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din(din1),
    .ready(ready1), .busy(busy1), .done(done1), .root(root1), .rem(rem1)
  );

  // Issues one operation on dut0 (sel=0) or dut1 (sel=1), then scrambles din;
  // lat is the number of edges after the start edge until done, or -1 on timeout.
  task automatic run_op(input bit sel, input logic [15:0] d, output int lat);
    @(negedge clk);
    if (sel) begin start1 = 1'b1; din1 = d; end
    else     begin start0 = 1'b1; din0 = d; end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    din0 = ~d; din1 = ~d;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (sel ? done1 : done0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready0, busy0, done0, root0, rem0} !== {1'b1, 1'b0, 1'b0, 8'd0, 9'd0}) begin
      errors++;
      $display("FAIL reset_dut0: got rdy=%0b busy=%0b done=%0b root=%0d rem=%0d want 1 0 0 0 0",
               ready0, busy0, done0, root0, rem0);
    end
    checks++;
    if ({ready1, busy1, done1, root1, rem1} !== {1'b1, 1'b0, 1'b0, 8'd0, 9'd0}) begin
      errors++;
      $display("FAIL reset_dut1: got rdy=%0b busy=%0b done=%0b root=%0d rem=%0d want 1 0 0 0 0",
               ready1, busy1, done1, root1, rem1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_floor();
    logic [15:0] vin [3]  = '{16'd0, 16'd144, 16'd65535};
    logic [7:0]  vrt [3]  = '{8'd0, 8'd12, 8'd255};
    logic [8:0]  vrm [3]  = '{9'd0, 9'd0, 9'd510};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, vin[k], lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL floor_latency din=%0d: got %0d want 8", vin[k], lat);
      end
      checks++;
      if (root0 !== vrt[k] || rem0 !== vrm[k]) begin
        errors++;
        $display("FAIL floor_result din=%0d: got root=%0d rem=%0d want root=%0d rem=%0d",
                 vin[k], root0, rem0, vrt[k], vrm[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (done0 !== 1'b0 || ready0 !== 1'b1) begin
        errors++;
        $display("FAIL floor_done_pulse din=%0d: got done=%0b ready=%0b want 0 1", vin[k], done0, ready0);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (root0 !== 8'd255 || rem0 !== 9'd510) begin
      errors++;
      $display("FAIL floor_hold: got root=%0d rem=%0d want 255 510", root0, rem0);
    end
  endtask

  task automatic test_round();
    logic [15:0] vin [3] = '{16'd156, 16'd157, 16'd65535};
    logic [7:0]  vrt [3] = '{8'd12, 8'd13, 8'd255};
    logic [8:0]  vrm [3] = '{9'd12, 9'd13, 9'd510};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b1, vin[k], lat);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL round_latency din=%0d: got %0d want 9", vin[k], lat);
      end
      checks++;
      if (root1 !== vrt[k] || rem1 !== vrm[k]) begin
        errors++;
        $display("FAIL round_result din=%0d: got root=%0d rem=%0d want root=%0d rem=%0d",
                 vin[k], root1, rem1, vrt[k], vrm[k]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int ndone = 0;
    @(negedge clk);
    start0 = 1'b1; din0 = 16'd2000;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (done0) ndone++;
      start0 = (c == 2 || c == 5);
      din0   = 16'd9999;
    end
    start0 = 1'b0;
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_busy_done_count: got %0d want 1", ndone);
    end
    checks++;
    if (root0 !== 8'd44 || rem0 !== 9'd64) begin
      errors++;
      $display("FAIL ignore_busy_result: got root=%0d rem=%0d want 44 64", root0, rem0);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(1'b0, 16'd50, lat);
    checks++;
    if (lat !== 8 || root0 !== 8'd7 || rem0 !== 9'd1) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d root=%0d rem=%0d want 8 7 1", lat, root0, rem0);
    end
    start0 = 1'b1; din0 = 16'd10000;
    @(posedge clk); #1;
    start0 = 1'b0; din0 = 16'd1;
    checks++;
    if (busy0 !== 1'b1 || ready0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b ready=%0b want 1 0", busy0, ready0);
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done0) begin lat = i; break; end
    end
    checks++;
    if (lat !== 8 || root0 !== 8'd100 || rem0 !== 9'd0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d root=%0d rem=%0d want 8 100 0", lat, root0, rem0);
    end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    int lat;
    @(negedge clk);
    start0 = 1'b1; din0 = 16'd12345;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready0, busy0, done0, root0, rem0} !== {1'b1, 1'b0, 1'b0, 8'd0, 9'd0}) begin
      errors++;
      $display("FAIL async_reset_dut0: got rdy=%0b busy=%0b done=%0b root=%0d rem=%0d want 1 0 0 0 0",
               ready0, busy0, done0, root0, rem0);
    end
    checks++;
    if (root1 !== 8'd0 || rem1 !== 9'd0) begin
      errors++;
      $display("FAIL async_reset_dut1: got root=%0d rem=%0d want 0 0", root1, rem1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done0) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL async_reset_no_done: got %0d pulses want 0", ndone);
    end
    run_op(1'b0, 16'd10000, lat);
    checks++;
    if (lat !== 8 || root0 !== 8'd100 || rem0 !== 9'd0) begin
      errors++;
      $display("FAIL async_reset_restart: got lat=%0d root=%0d rem=%0d want 8 100 0", lat, root0, rem0);
    end
  endtask

  initial begin
    test_reset();
    test_floor();
    test_round();
    test_ignore_busy();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_isqrt_n.md
Name: seq_isqrt_n

Overview:
- Multi-cycle, parametrised integer square root unit: restoring digit-by-digit algorithm, one root bit per clock.
- Generalises the fixed-width 11-bit datapath to any even operand width.
- Adds a start/ready/done handshake, a remainder output and an optional round-to-nearest mode.
- Feeds downstream fixed-point stages; results are held stable until the next accepted operation.

Parameters:
- WIDTH, 16, operand width in bits; must be even and at least 4.
- ROUND, 0, 0 = floor root; 1 = round root to nearest, saturating at all-ones.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- din  in  WIDTH  unsigned radicand, sampled on the accepting edge
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; results are valid from this cycle on
- root  out  WIDTH/2  floor or rounded sqrt(din)
- rem  out  WIDTH/2+1  din - floor_root^2; always the unrounded remainder

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; root=0, rem=0, done=0, busy=0, ready=1; internal operand, partial remainder and counter cleared.
  - Applies immediately, including mid-operation; the in-flight result is discarded and no done pulse is produced.
- States: IDLE, CALC, FIX (present only when ROUND=1), DONE.
- IDLE or DONE with start=1 (edge E0):
  - latch din into the shift operand; clear the partial root and partial remainder; counter=WIDTH/2-1; go to CALC.
- CALC, one iteration per edge:
  - trial = (prem<<2) | top two operand bits; width WIDTH/2+3, no truncation.
  - test = (proot<<2) | 1.
  - If trial >= test: prem = trial - test, proot = (proot<<1)|1. Otherwise prem = trial, proot = proot<<1.
  - Shift the operand left by 2. Decrement the counter.
- Exit from CALC, on the edge where counter==0 (edge E(WIDTH/2)):
  - ROUND=0: load root/rem output registers, go to DONE.
  - ROUND=1: go to FIX.
- FIX, one edge:
  - root = proot + 1 if prem > proot, else proot; saturate at 2^(WIDTH/2)-1.
  - rem = prem; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE unless start=1, in which case a new operation is accepted on that same edge (back-to-back issue).
- Latency from the start edge to the first cycle with done=1: WIDTH/2 edges when ROUND=0, WIDTH/2+1 edges when ROUND=1.
- Throughput: one result per WIDTH/2+1 cycles (ROUND=0) or WIDTH/2+2 cycles (ROUND=1).
- start while busy=1 is ignored entirely: no queueing, no error, outputs unchanged.
- root/rem change only on the edge that enters DONE (or FIX→DONE). They hold through IDLE and through the next computation until its completion.
- din is sampled only on the accepting edge; later changes have no effect.
- Range: rem <= 2*root always fits WIDTH/2+1 bits. The comparison uses an unsigned borrow-out compare, never a signed one.

Decomposition:
- Shared package:
  - state encoding constants (IDLE, CALC, FIX, DONE);
  - ITER = WIDTH/2;
  - counter width = clog2(ITER);
  - derived widths RW = WIDTH/2 and PW = WIDTH/2+3.
- One combinational sub-module, isqrt_step_n (parameter WIDTH): takes prem, proot and the two operand bits; returns next prem, next proot and the take/skip bit.
  - Built on the existing subtractor, gte comparator and 2:1 mux vector blocks.
- Top level holds the registers, counter, FSM and the rounding incrementer.

Test Plan:
- WIDTH=16, ROUND=0, din=0 → root=0, rem=0; done exactly 8 edges after start.
- WIDTH=16, ROUND=0: din=144 → root=12, rem=0; din=65535 → root=255, rem=510.
- WIDTH=16, ROUND=1: din=156 → root=12, rem=12; din=157 → root=13, rem=13; din=65535 → root=255 (saturated), rem=510; done 9 edges after start.
- start pulsed at cycles 2 and 5 of a busy computation with different din → ignored; result still matches the first din; a single done pulse.
- start held high in the DONE cycle with din=10000 → accepted back-to-back; next done gives root=100, rem=0, with no IDLE cycle between.
- rst_n dropped asynchronously mid-CALC (between edges) → outputs go to 0 and ready=1 immediately; no done follows; a fresh start after release completes correctly.
